ram_rr_arbiter: RTL
===================

Name: ram_rr_arbiter

Overview:
- Two-client round-robin arbiter in front of the team's simple dual-port RAM.
- The RAM has a synchronous write, a registered read address and a 1-cycle read latency.
- Each client issues single read or write commands with a req/gnt handshake. The arbiter grants one command per cycle, drives the RAM ports, and returns read data to the issuing client with an rvalid strobe.
- Sits between datapath clients (e.g. the GF table builder and the lookup engine) and one RAM instance.

Parameters:
- DWIDTH, 8, data width; must match the RAM.
- AWIDTH, 10, address width; must match the RAM.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req0  in  1  client 0 command request
- we0  in  1  client 0: 1 = write, 0 = read
- addr0  in  AWIDTH  client 0 address
- wdata0  in  DWIDTH  client 0 write data
- gnt0  out  1  client 0 command accepted this cycle
- rvalid0  out  1  read data for client 0 valid this cycle
- req1, we1, addr1, wdata1, gnt1, rvalid1: same as client 0, for client 1
- rdata  out  DWIDTH  read data, shared; qualified by rvalid0/rvalid1
- ram_wen  out  1  to RAM wen
- ram_waddr  out  AWIDTH  to RAM waddr
- ram_din  out  DWIDTH  to RAM din
- ram_raddr  out  AWIDTH  to RAM raddr
- ram_dout  in  DWIDTH  from RAM dout

Behaviour:
- Clock is clk. Reset is rst_n, synchronous and active-low; there is one clock domain.
- State:
  - last_gnt (1 bit): client granted most recently.
  - rd_pend (1 bit): a read was granted last cycle.
  - rd_id (1 bit): client that owns the pending read.
- Reset values:
  - last_gnt = 1, so client 0 has priority on the first contention.
  - rd_pend = 0, rd_id = 0.
  - While rst_n = 0: gnt0 = gnt1 = 0, ram_wen = 0, rvalid0 = rvalid1 = 0.
  - ram_waddr, ram_din, ram_raddr and rdata are don't-care during reset; the implementation drives 0.
- Arbitration is combinational within the cycle:
  - Only req0 asserted: gnt0 = 1.
  - Only req1 asserted: gnt1 = 1.
  - Both asserted: grant the client that is not last_gnt.
  - At most one gnt is high per cycle. gnt depends only on req and last_gnt, never on we/addr.
- Handshake: a command transfers on a cycle with req = gnt = 1. The client holds req/we/addr/wdata stable until granted. Dropping req before a grant is legal and withdraws the command.
- last_gnt updates at the clock edge to the granted client whenever any grant occurs. It holds otherwise, so an idle cycle does not change priority.
- Back-to-back: a client with continuous req and no competitor is granted every cycle. Under continuous contention grants strictly alternate 0,1,0,1…
- Granted write:
  - ram_wen = 1, ram_waddr = addr, ram_din = wdata in the same cycle; data is committed at that edge.
  - No rvalid is generated.
- Granted read:
  - ram_raddr = addr in the grant cycle, captured by the RAM at the edge.
  - rd_pend <= 1 and rd_id <= granted client.
  - In the following cycle rvalid[rd_id] = 1 and rdata = ram_dout. Read latency is exactly 1 cycle after grant.
- No grant: ram_wen = 0, ram_raddr = 0, rd_pend <= 0.
- rvalid is asserted for exactly one cycle per granted read. Back-to-back reads produce back-to-back rvalids in grant order.
- Write at address A granted in cycle N, then a read of A granted in cycle N+1: the read returns the new data, because the write commits before the read address is registered.
- Only one command is granted per cycle, so there are no same-cycle read/write collisions.
- Reset asserted mid-operation:
  - A pending read is discarded; no rvalid follows reset.
  - Priority returns to client 0.
  - RAM contents are not cleared.

Test Plan:
- Reset then idle: rst_n = 0 for 3 cycles, then 1 with no req -> all gnt/rvalid = 0, ram_wen = 0 throughout.
- Single write then read: client0 writes 0x5A to addr 0x010, next cycle reads 0x010 -> gnt0 both cycles; rvalid0 = 1 one cycle after the read grant with rdata = 0x5A; rvalid1 stays 0.
- Contention: req0 = req1 = 1 held for 6 cycles of reads to different addresses -> grant order 0,1,0,1,0,1. rvalid pattern follows one cycle later, each with the correct data.
- Mixed: client0 write 0xA5 to 0x3FF while client1 requests a read of 0x3FF in the same cycle (first contention after reset) -> client0 granted first. Client1 is granted next cycle and receives 0xA5 one cycle later.
- Withdrawal: req1 asserted while client0 holds the grant, then dropped before being granted -> gnt1 never asserts; last_gnt unchanged by idle cycles.
- Reset mid-read: read granted at cycle N, rst_n = 0 at cycle N+1 -> rvalid0/rvalid1 = 0 at N+1. After release, contention grants client 0 first.

Source files
------------

// File: rtl/ram_rr_arbiter_if.sv
// Client command/response and RAM port bundle for the two-client RAM arbiter.
// The slave modport is the arbiter; the master modport is the surrounding clients plus RAM.
interface ram_rr_arbiter_if #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 10
);
    logic              req0;
    logic              we0;
    logic [AWIDTH-1:0] addr0;
    logic [DWIDTH-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;

    logic              req1;
    logic              we1;
    logic [AWIDTH-1:0] addr1;
    logic [DWIDTH-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;

    logic [DWIDTH-1:0] rdata;

    logic              ram_wen;
    logic [AWIDTH-1:0] ram_waddr;
    logic [DWIDTH-1:0] ram_din;
    logic [AWIDTH-1:0] ram_raddr;
    logic [DWIDTH-1:0] ram_dout;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_dout,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
        output ram_wen, ram_waddr, ram_din, ram_raddr
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_dout,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata,
        input  ram_wen, ram_waddr, ram_din, ram_raddr
    );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Two-client round-robin arbiter for a simple dual-port RAM: one command granted per
// cycle, writes committed at the grant edge, read data returned one cycle after grant.
module ram_rr_arbiter #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_rr_arbiter_if.slave     io_bus
);

    logic              r_last_gnt;
    logic              r_rd_pend;
    logic              r_rd_id;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any;
    logic              w_sel_we;
    logic [AWIDTH-1:0] w_sel_addr;
    logic [DWIDTH-1:0] w_sel_wdata;
    logic              w_wr;
    logic              w_rd;

    // Grant depends only on requests and priority; the loser of the last grant wins ties.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            if (io_bus.req0 && (!io_bus.req1 || r_last_gnt)) begin
                w_gnt0 = 1'b1;
            end else if (io_bus.req1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        w_any       = w_gnt0 | w_gnt1;
        w_sel_we    = w_gnt1 ? io_bus.we1    : io_bus.we0;
        w_sel_addr  = w_gnt1 ? io_bus.addr1  : io_bus.addr0;
        w_sel_wdata = w_gnt1 ? io_bus.wdata1 : io_bus.wdata0;
        w_wr        = w_any & w_sel_we;
        w_rd        = w_any & ~w_sel_we;
    end

    assign io_bus.gnt0      = w_gnt0;
    assign io_bus.gnt1      = w_gnt1;
    assign io_bus.ram_wen   = w_wr;
    assign io_bus.ram_waddr = w_wr ? w_sel_addr  : '0;
    assign io_bus.ram_din   = w_wr ? w_sel_wdata : '0;
    assign io_bus.ram_raddr = w_rd ? w_sel_addr  : '0;

    // Read response: reset kills a pending read in the same cycle it is asserted.
    assign io_bus.rvalid0 = rst_n & r_rd_pend & ~r_rd_id;
    assign io_bus.rvalid1 = rst_n & r_rd_pend &  r_rd_id;
    assign io_bus.rdata   = (rst_n && r_rd_pend) ? io_bus.ram_dout : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
            r_rd_pend  <= 1'b0;
            r_rd_id    <= 1'b0;
        end else begin
            if (w_any) begin
                r_last_gnt <= w_gnt1;
            end
            r_rd_pend <= w_rd;
            if (w_rd) begin
                r_rd_id <= w_gnt1;
            end
        end
    end

endmodule
